// File: rtl/freelist_ckpt.sv
// Multi-port physical-tag free list with an in-order checkpoint queue for rename recovery.
// Optional sticky misuse detector on err: define FREELIST_CKPT_ERRCHK_EN.
module freelist_ckpt #(
    parameter int DEPTH = 32,
    parameter int READ  = 4,
    parameter int WRITE = 4,
    parameter int CKPT  = 4,
    parameter int RSV   = 0,
    localparam int TAG  = $clog2(DEPTH),
    localparam int CKW  = $clog2(CKPT)
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   flush_,
    input  logic [READ-1:0]        re_,
    output logic [READ*TAG-1:0]    rd,
    output logic [READ-1:0]        v,
    input  logic [WRITE-1:0]       we_,
    input  logic [WRITE*TAG-1:0]   wd,
    input  logic                   ck_we_,
    output logic [CKW-1:0]         ck_id,
    output logic                   ck_full,
    input  logic                   rel_,
    input  logic                   rb_,
    input  logic [CKW-1:0]         rb_id,
    output logic [TAG:0]           free_cnt,
    output logic                   busy,
    output logic                   err
);

    localparam logic [DEPTH-1:0] RSV_MASK = (DEPTH'(1) << RSV) - DEPTH'(1);
    localparam logic [TAG:0]     RST_FREE = (TAG+1)'(DEPTH - RSV);

    logic [DEPTH-1:0] usage, alloc, freed, next_usage;
    logic [DEPTH-1:0] snap [CKPT];
    logic [TAG-1:0]   offer [READ];
    logic [TAG:0]     next_free;
    logic [CKW-1:0]   head, tail, head_n;
    logic [CKW:0]     count;
    logic             rollback, do_ck, do_rel;

    assign rollback = !rb_;
    assign ck_full  = (count == (CKW+1)'(CKPT));
    assign ck_id    = tail;
    assign do_ck    = !ck_we_ && !ck_full && rb_;
    assign do_rel   = !rel_ && (count != '0);

    // Port k takes the k-th lowest free tag; no bypass from same-cycle frees.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < READ; k++) offer[k] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!usage[i]) begin
                for (int k = 0; k < READ; k++)
                    if (n == k) offer[k] = TAG'(i);
                n++;
            end
        end
    end

    for (genvar k = 0; k < READ; k++) begin : g_port
        assign rd[k*TAG +: TAG] = offer[k];
        // free_cnt always equals the number of clear usage bits.
        assign v[k] = rb_ && (free_cnt > (TAG+1)'(k));
    end

    always_comb begin
        alloc = '0;
        for (int k = 0; k < READ; k++)
            if (!re_[k] && v[k]) alloc[offer[k]] = 1'b1;
    end

    always_comb begin
        freed = '0;
        for (int j = 0; j < WRITE; j++)
            if (!we_[j]) freed[wd[j*TAG +: TAG]] = 1'b1;
    end

    assign next_usage = rollback ? (snap[rb_id] & ~freed) : ((usage | alloc) & ~freed);

    always_comb begin
        next_free = '0;
        for (int i = 0; i < DEPTH; i++)
            next_free = next_free + (TAG+1)'(!next_usage[i]);
    end

    // A release that hits the rollback target must not move head past the emptied queue.
    assign head_n = (do_rel && !(rollback && rb_id == head)) ? head + CKW'(1) : head;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            usage    <= RSV_MASK;
            free_cnt <= RST_FREE;
            busy     <= (RST_FREE < (TAG+1)'(READ));
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (!flush_) begin
            usage    <= RSV_MASK;
            free_cnt <= RST_FREE;
            busy     <= (RST_FREE < (TAG+1)'(READ));
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            usage    <= next_usage;
            free_cnt <= next_free;
            busy     <= (next_free < (TAG+1)'(READ));
            head     <= head_n;
            if (rollback) begin
                tail  <= rb_id;
                count <= {1'b0, rb_id - head_n};
            end else begin
                tail  <= tail + CKW'(do_ck);
                count <= count + (CKW+1)'(do_ck) - (CKW+1)'(do_rel);
            end
        end
    end

    // NOTE: snapshot storage has no reset; a slot is only read after a checkpoint wrote it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < CKPT; s++) begin
            if (do_ck && tail == CKW'(s))
                snap[s] <= next_usage;
            else
                snap[s] <= snap[s] & ~freed;
        end
    end

`ifdef FREELIST_CKPT_ERRCHK_EN
    logic           err_q, bad_free, bad_rb, bad_rel, bad_ck;
    logic [CKW-1:0] rb_off;

    always_comb begin
        bad_free = 1'b0;
        for (int j = 0; j < WRITE; j++)
            if (!we_[j] && !usage[wd[j*TAG +: TAG]] && !alloc[wd[j*TAG +: TAG]])
                bad_free = 1'b1;
    end

    assign rb_off  = rb_id - head;
    assign bad_rb  = rollback && ({1'b0, rb_off} >= count);
    assign bad_rel = !rel_ && (count == '0);
    assign bad_ck  = !ck_we_ && ck_full && rb_;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            err_q <= 1'b0;
        else if (!flush_)
            err_q <= 1'b0;
        else if (bad_free || bad_rb || bad_rel || bad_ck)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_ckpt.sv
// Scoreboard bench for freelist_ckpt (DEPTH=32, READ=4, WRITE=4, CKPT=4, RSV=8):
// the driver queues expected values, a negedge monitor pops and compares them.
module tb_freelist_ckpt;

    localparam int TAG = 5;
`ifdef FREELIST_CKPT_ERRCHK_EN
    localparam logic [31:0] ERR_ON = 32'd1;
`else
    localparam logic [31:0] ERR_ON = 32'd0;
`endif

    logic             clk, reset_, flush_;
    logic [3:0]       re_, v, we_;
    logic [4*TAG-1:0] rd, wd;
    logic             ck_we_, ck_full, rel_, rb_, busy, err;
    logic [1:0]       ck_id, rb_id;
    logic [TAG:0]     free_cnt;

    freelist_ckpt #(.DEPTH(32), .READ(4), .WRITE(4), .CKPT(4), .RSV(8)) dut (
        .clk(clk), .reset_(reset_), .flush_(flush_),
        .re_(re_), .rd(rd), .v(v),
        .we_(we_), .wd(wd),
        .ck_we_(ck_we_), .ck_id(ck_id), .ck_full(ck_full),
        .rel_(rel_), .rb_(rb_), .rb_id(rb_id),
        .free_cnt(free_cnt), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {S_RD0, S_RD1, S_RD2, S_RD3, S_V, S_FREE, S_BUSY, S_FULL, S_CKID, S_ERR} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [31:0] actual(sel_e s);
        case (s)
            S_RD0:   return 32'(rd[0*TAG +: TAG]);
            S_RD1:   return 32'(rd[1*TAG +: TAG]);
            S_RD2:   return 32'(rd[2*TAG +: TAG]);
            S_RD3:   return 32'(rd[3*TAG +: TAG]);
            S_V:     return 32'(v);
            S_FREE:  return 32'(free_cnt);
            S_BUSY:  return 32'(busy);
            S_FULL:  return 32'(ck_full);
            S_CKID:  return 32'(ck_id);
            default: return 32'(err);
        endcase
    endfunction

    task automatic push_exp(input string name, input sel_e sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endtask

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                exp_t        e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.sel);
                n_vec++;
                if (a !== e.val) begin
                    n_miss++;
                    $display("FAIL %s: got %0d, expected %0d", e.name, a, e.val);
                end
            end
        end
    end

    task automatic idle();
        flush_ = 1'b1; re_ = '1; we_ = '1; wd = '0;
        ck_we_ = 1'b1; rel_ = 1'b1; rb_ = 1'b1; rb_id = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic exp_reset_state(input string tag);
        push_exp({tag, "_rd0"}, S_RD0, 8);
        push_exp({tag, "_rd1"}, S_RD1, 9);
        push_exp({tag, "_rd2"}, S_RD2, 10);
        push_exp({tag, "_rd3"}, S_RD3, 11);
        push_exp({tag, "_v"},    S_V,    4'b1111);
        push_exp({tag, "_free"}, S_FREE, 24);
        push_exp({tag, "_busy"}, S_BUSY, 0);
        push_exp({tag, "_full"}, S_FULL, 0);
        push_exp({tag, "_ckid"}, S_CKID, 0);
        push_exp({tag, "_err"},  S_ERR,  0);
    endtask

    initial begin
        idle();
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;

        exp_reset_state("reset");
        tick();

        // Drain the pool: 4 per cycle for 6 cycles.
        for (int c = 0; c < 6; c++) begin
            re_ = '0;
            push_exp("drain_v", S_V, 4'b1111);
            if (c == 1) begin
                push_exp("drain_rd0", S_RD0, 12);
                push_exp("drain_free", S_FREE, 20);
            end
            tick();
        end
        push_exp("empty_free", S_FREE, 0);
        push_exp("empty_busy", S_BUSY, 1);
        push_exp("empty_v",    S_V,    0);

        we_ = 4'b1110; wd[0 +: TAG] = 5'd17;
        tick();
        push_exp("free17_rd0",  S_RD0,  17);
        push_exp("free17_v",    S_V,    4'b0001);
        push_exp("free17_free", S_FREE, 1);
        push_exp("free17_busy", S_BUSY, 1);

        // Flush wins over a same-cycle allocation.
        flush_ = 1'b0; re_ = '0;
        tick();
        exp_reset_state("flush1");

        we_ = 4'b1110; wd[0 +: TAG] = 5'd20;
        tick();
        push_exp("dblfree_err",  S_ERR,  ERR_ON);
        push_exp("dblfree_free", S_FREE, 24);
        tick();
        push_exp("dblfree_hold", S_ERR, ERR_ON);
        flush_ = 1'b0;
        tick();
        push_exp("flush2_err", S_ERR, 0);

        // Checkpoint / rollback recovery.
        re_ = '0;
        tick();
        push_exp("ck0_id",   S_CKID, 0);
        push_exp("ck0_free", S_FREE, 20);
        ck_we_ = 1'b0;
        tick();
        push_exp("ck0_tail", S_CKID, 1);
        re_ = '0;
        tick();
        push_exp("alloc12_free", S_FREE, 16);
        push_exp("alloc12_rd0",  S_RD0,  16);
        we_ = 4'b1110; wd[0 +: TAG] = 5'd9;
        tick();
        push_exp("free9_rd0",  S_RD0,  9);
        push_exp("free9_free", S_FREE, 17);
        rb_ = 1'b0; rb_id = 2'd0; re_ = '0;
        push_exp("rb_v_forced", S_V, 0);
        tick();
        push_exp("rb_free", S_FREE, 21);
        push_exp("rb_rd0",  S_RD0,  9);
        push_exp("rb_rd1",  S_RD1,  12);
        push_exp("rb_rd2",  S_RD2,  13);
        push_exp("rb_tail", S_CKID, 0);
        push_exp("rb_v",    S_V,    4'b1111);

        // Fill the checkpoint queue, overflow, release, wrap.
        for (int i = 0; i < 4; i++) begin
            ck_we_ = 1'b0;
            push_exp("fill_id", S_CKID, 32'(i));
            push_exp("fill_notfull", S_FULL, 0);
            tick();
        end
        push_exp("full",      S_FULL, 1);
        push_exp("full_tail", S_CKID, 0);
        ck_we_ = 1'b0;
        tick();
        push_exp("ovf_full", S_FULL, 1);
        push_exp("ovf_tail", S_CKID, 0);
        push_exp("ovf_err",  S_ERR,  ERR_ON);
        rel_ = 1'b0;
        tick();
        push_exp("rel_full", S_FULL, 0);
        push_exp("rel_tail", S_CKID, 0);
        ck_we_ = 1'b0;
        push_exp("wrap_id", S_CKID, 0);
        tick();
        push_exp("wrap_full", S_FULL, 1);
        push_exp("wrap_tail", S_CKID, 1);

        // Rollback to head with release, checkpoint and allocate in the same cycle.
        rb_ = 1'b0; rb_id = 2'd1; rel_ = 1'b0; ck_we_ = 1'b0; re_ = '0;
        push_exp("combo_v", S_V, 0);
        tick();
        push_exp("combo_full", S_FULL, 0);
        push_exp("combo_tail", S_CKID, 1);
        push_exp("combo_free", S_FREE, 21);
        push_exp("combo_rd0",  S_RD0,  9);

        // Four more checkpoints only fit if the queue really emptied.
        for (int i = 0; i < 4; i++) begin
            ck_we_ = 1'b0;
            push_exp("refill_id", S_CKID, 32'((i + 1) % 4));
            push_exp("refill_notfull", S_FULL, 0);
            tick();
        end
        push_exp("refill_full", S_FULL, 1);

        // Only port 2 allocates.
        re_ = 4'b1011;
        tick();
        push_exp("p2_free", S_FREE, 20);
        push_exp("p2_rd0",  S_RD0,  9);
        push_exp("p2_rd1",  S_RD1,  12);
        push_exp("p2_rd2",  S_RD2,  14);
        push_exp("p2_v",    S_V,    4'b1111);

        flush_ = 1'b0;
        tick();
        exp_reset_state("flush3");
        tick();

        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
